// File: rtl/ext_link_pkg.sv
// ext_link_pkg: shared definitions for the external serial link.
// Holds the link state enumeration, default frame/baud/timeout constants
// and a helper that classifies states waiting on a line edge. Also used by
// the ext_interface benches so that both ends agree on the framing.
package ext_link_pkg;

    localparam int          LINK_PACKET_WIDTH = 10;      // {prefix[1:0], data[7:0]}
    localparam logic [15:0] LINK_DEFAULT_BAUD = 16'd8;
    localparam logic [15:0] LINK_TIMEOUT_CYC  = 16'd4096;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_O_CAL,
        ST_O_ACK_LO,
        ST_O_ACK_HI,
        ST_O_GAP,
        ST_O_START,
        ST_O_BITS,
        ST_O_ACK2_LO,
        ST_O_ACK2_HI,
        ST_I_REQ,
        ST_I_ACK,
        ST_I_WAIT,
        ST_I_HALF,
        ST_I_BITS,
        ST_I_STOP,
        ST_I_ACK2
    } link_state_e;

    // States whose exit depends only on the far end moving the line; these
    // are the ones guarded by the timeout counter.
    function automatic logic is_line_wait(input link_state_e s);
        return (s == ST_O_ACK_LO)  || (s == ST_O_ACK_HI)  ||
               (s == ST_O_ACK2_LO) || (s == ST_O_ACK2_HI) ||
               (s == ST_I_REQ)     || (s == ST_I_WAIT);
    endfunction

endpackage

// File: rtl/link_bit_timer.sv
// link_bit_timer: down-counting bit timer shared by both link directions.
// A start pulse loads the period (or half of it when half=1); tick is high
// for the single cycle in which the count sits at its terminal value, so a
// state that starts the timer on entry lasts exactly the loaded period.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   start      load a new period (overrides a running count)
//   half       load load_val/2 instead of load_val
//   load_val   period in clk cycles
//   tick       terminal-count pulse
module link_bit_timer
    import ext_link_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        half,
    input  logic [15:0] load_val,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [15:0] period;

    always_comb begin
        period = half ? {1'b0, load_val[15:1]} : load_val;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            // A zero period behaves like one cycle rather than wrapping.
            cnt_d = (period == 16'd0) ? 16'd0 : period - 16'd1;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == 16'd0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign tick = run_q && (cnt_q == 16'd0);

endmodule

// File: rtl/ext_link_peer.sv
// ext_link_peer: far-end serial endpoint for the ext_interface tx/rx pair.
// Outbound: calibration pulse, wait ack, framed packet, wait ack.
// Inbound:  measure request pulse, echo it as ack, receive frame at the
//           measured bit length, ack with a BAUD_SIZE low pulse.
// rx is taken to be synchronous to clk (both ends share the board clock).
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   tx / rx    serial lines, idle high
//   tx_data, tx_valid, tx_ready   host packet in (valid/ready)
//   rx_data, rx_valid             received packet out, rx_valid one cycle
//   busy       high outside IDLE
//   error      one-cycle pulse on abort
//
// state        | meaning
// IDLE         | line idle, accepts host packet or inbound request
// O_CAL        | drive calibration low pulse, BAUD_SIZE cycles
// O_ACK_LO/HI  | wait for interface ack low then high
// O_GAP        | hold high 2*BAUD_SIZE while interface prepares
// O_START      | start bit
// O_BITS       | packet bits MSB first
// O_ACK2_LO/HI | wait for frame ack low then high
// I_REQ        | measure request low length L
// I_ACK        | echo L-cycle low ack
// I_WAIT       | wait for start bit
// I_HALF       | move to mid start bit, confirm still low
// I_BITS       | sample PACKET_WIDTH bits every L cycles
// I_STOP       | wait for line to return high
// I_ACK2       | publish packet, drive BAUD_SIZE low ack
module ext_link_peer
    import ext_link_pkg::*;
#(
    parameter logic [15:0] BAUD_SIZE    = LINK_DEFAULT_BAUD,
    parameter int          PACKET_WIDTH = LINK_PACKET_WIDTH,
    parameter logic [15:0] TIMEOUT_CYC  = LINK_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    tx,
    input  logic                    rx,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [PACKET_WIDTH-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    busy,
    output logic                    error
);

    localparam logic [7:0]  LAST_BIT = 8'(PACKET_WIDTH - 1);
    localparam logic [15:0] GAP_CYC  = {BAUD_SIZE[14:0], 1'b0};

    link_state_e             state_q, state_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             to_q, to_d;
    logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    error_q, error_d;
    logic                    ready_q, ready_d;

    logic        t_start, t_half, t_tick;
    logic [15:0] t_load;
    logic        abort;

    link_bit_timer u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .start    (t_start),
        .half     (t_half),
        .load_val (t_load),
        .tick     (t_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 8'd0;
            len_q      <= 16'd0;
            to_q       <= 16'd0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            to_q       <= to_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        error_d    = 1'b0;
        ready_d    = 1'b1;       // holds tx_ready low only for the reset cycle
        t_start    = 1'b0;
        t_half     = 1'b0;
        t_load     = BAUD_SIZE;
        abort      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Inbound request takes priority; a pending host packet waits.
                if (!rx) begin
                    state_d = ST_I_REQ;
                    len_d   = 16'd1;
                end else if (tx_valid && ready_q) begin
                    state_d = ST_O_CAL;
                    shift_d = tx_data;
                    t_start = 1'b1;
                end
            end
            ST_O_CAL: if (t_tick) state_d = ST_O_ACK_LO;
            ST_O_ACK_LO: if (!rx) state_d = ST_O_ACK_HI;
            ST_O_ACK_HI: begin
                if (rx) begin
                    state_d = ST_O_GAP;
                    t_start = 1'b1;
                    t_load  = GAP_CYC;
                end
            end
            ST_O_GAP: begin
                if (t_tick) begin
                    state_d = ST_O_START;
                    t_start = 1'b1;
                end
            end
            ST_O_START: begin
                if (t_tick) begin
                    state_d   = ST_O_BITS;
                    bit_cnt_d = 8'd0;
                    t_start   = 1'b1;
                end
            end
            ST_O_BITS: begin
                if (t_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_O_ACK2_LO;
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        t_start   = 1'b1;
                    end
                end
            end
            ST_O_ACK2_LO: if (!rx) state_d = ST_O_ACK2_HI;
            ST_O_ACK2_HI: if (rx) state_d = ST_IDLE;
            ST_I_REQ: begin
                if (rx) begin
                    if (len_q < 16'd2) begin
                        abort = 1'b1;
                    end else begin
                        state_d = ST_I_ACK;
                        t_start = 1'b1;
                        t_load  = len_q;
                    end
                end else if (len_q != 16'hFFFF) begin
                    len_d = len_q + 16'd1;
                end
            end
            ST_I_ACK: if (t_tick) state_d = ST_I_WAIT;
            ST_I_WAIT: begin
                if (!rx) begin
                    state_d = ST_I_HALF;
                    t_start = 1'b1;
                    t_half  = 1'b1;
                    t_load  = len_q;
                end
            end
            ST_I_HALF: begin
                if (t_tick) begin
                    if (rx) begin
                        abort = 1'b1;
                    end else begin
                        state_d   = ST_I_BITS;
                        bit_cnt_d = 8'd0;
                        t_start   = 1'b1;
                        t_load    = len_q;
                    end
                end
            end
            ST_I_BITS: begin
                if (t_tick) begin
                    shift_d = {shift_q[PACKET_WIDTH-2:0], rx};
                    t_start = 1'b1;
                    t_load  = len_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_I_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            ST_I_STOP: begin
                if (rx) begin
                    state_d    = ST_I_ACK2;
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    t_start    = 1'b1;
                end else if (t_tick) begin
                    abort = 1'b1;
                end
            end
            ST_I_ACK2: if (t_tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (is_line_wait(state_q) && (to_q == TIMEOUT_CYC)) begin
            abort = 1'b1;
        end
        if (abort) begin
            state_d    = ST_IDLE;
            error_d    = 1'b1;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end

        if (state_d != state_q) begin
            to_d = 16'd0;
        end else if (is_line_wait(state_q)) begin
            to_d = to_q + 16'd1;
        end else begin
            to_d = 16'd0;
        end
    end

    always_comb begin
        case (state_q)
            ST_O_CAL, ST_O_START, ST_I_ACK, ST_I_ACK2: tx = 1'b0;
            ST_O_BITS: tx = shift_q[PACKET_WIDTH-1];
            default:   tx = 1'b1;
        endcase
        busy     = (state_q != ST_IDLE);
        tx_ready = ready_q && (state_q == ST_IDLE) && rx;
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ext_link_peer.sv
module tb_ext_link_peer;

    localparam int B  = 8;
    localparam int PW = 10;
    localparam int TO = 4096;

    logic          clk;
    logic          rstn;
    logic          tx;
    logic          rx;
    logic [PW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [PW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          error;

    int errors = 0;
    int checks = 0;

    int          mon_vcount;
    int          mon_txlow;
    int          mon_err;
    logic [PW-1:0] mon_vdata;

    ext_link_peer dut (
        .clk      (clk),
        .rstn     (rstn),
        .tx       (tx),
        .rx       (rx),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          inbound;
        logic [9:0]  data;
        int          len;      // inbound request/bit length
        int          resp;     // outbound ack pulse length
        bit          exp_err;
        int          exp_ack;  // outbound: cal pulse length; inbound: ack length
        logic [9:0]  exp_rx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic step_mon();
        tick1();
        if (rx_valid) begin
            mon_vcount++;
            mon_vdata = rx_data;
        end
        if (tx == 1'b0) mon_txlow++;
        if (error) mon_err++;
    endtask

    // Outbound packet with the bench acting as the interface responder.
    task automatic run_outbound(input logic [9:0] d, input int delay, input int ack_len,
                                input int exp_cal);
        int   n;
        int   bad;
        logic exp_q[$];
        tx_data  = d;
        tx_valid = 1'b1;
        tick1();
        tx_valid = 1'b0;
        tx_data  = 10'($urandom);
        check("out_busy", busy, 1);
        check("out_ready_low", tx_ready, 0);
        n = 0;
        while (tx == 1'b0 && n < 100) begin n++; tick1(); end
        check("cal_len", n, exp_cal);
        repeat (delay) tick1();
        check("ack_wait_tx_high", tx, 1);
        rx = 1'b0;
        repeat (ack_len) tick1();
        rx = 1'b1;
        n = 0;
        tick1();
        while (tx == 1'b1 && n < 100) begin n++; tick1(); end
        check("gap_len", n, 2 * B);
        // Expected line: start bit, then each packet bit MSB first, B cycles each.
        for (int i = 0; i < B; i++) exp_q.push_back(1'b0);
        for (int b = PW - 1; b >= 0; b--)
            for (int i = 0; i < B; i++) exp_q.push_back(d[b]);
        bad = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (tx !== exp_q[k]) bad++;
            tick1();
        end
        check("frame_wave_bad_cycles", bad, 0);
        check("line_high_after_frame", tx, 1);
        rx = 1'b0;
        repeat (ack_len) tick1();
        check("busy_before_ack2", busy, 1);
        rx = 1'b1;
        tick1();
        check("out_done_busy", busy, 0);
        check("out_done_ready", tx_ready, 1);
    endtask

    // Inbound request + frame driven by the bench at L cycles per bit.
    task automatic run_inbound(input logic [9:0] d, input int L, input bit exp_err,
                               input int exp_ack, input logic [9:0] exp_rx);
        int n;
        rx = 1'b0;
        repeat (L) tick1();
        rx = 1'b1;
        if (exp_err) begin
            tick1();
            check("glitch_error", error, 1);
            check("glitch_busy", busy, 0);
            check("glitch_rx_valid", rx_valid, 0);
            n = 0;
            repeat (2 * B) begin
                if (tx == 1'b0) n++;
                tick1();
            end
            check("glitch_no_ack_cycles", n, 0);
            check("glitch_error_cleared", error, 0);
            return;
        end
        n = 0;
        tick1();
        while (tx == 1'b0 && n < 200) begin n++; tick1(); end
        check("in_ack_len", n, exp_ack);
        mon_vcount = 0;
        mon_txlow  = 0;
        mon_err    = 0;
        mon_vdata  = '0;
        rx = 1'b0;
        repeat (L) step_mon();
        for (int b = PW - 1; b >= 0; b--) begin
            rx = d[b];
            repeat (L) step_mon();
        end
        rx = 1'b1;
        n = 0;
        while (busy && n < 200) begin step_mon(); n++; end
        check("in_done_busy", busy, 0);
        check("in_rx_valid_pulses", mon_vcount, 1);
        check("in_rx_data_at_valid", mon_vdata, exp_rx);
        check("in_rx_data_held", rx_data, exp_rx);
        check("in_ack2_len", mon_txlow, B);
        check("in_no_error", mon_err, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        logic [9:0] d;
        int   L;

        vecs[0] = '{1'b0, 10'h2A5, 0,  2, 1'b0, B,  10'h000};
        vecs[1] = '{1'b1, 10'h155, 12, 0, 1'b0, 12, 10'h155};
        vecs[2] = '{1'b1, 10'h000, 1,  0, 1'b1, 0,  10'h000};
        vecs[3] = '{1'b0, 10'h3FF, 0,  1, 1'b0, B,  10'h000};
        vecs[4] = '{1'b1, 10'h2AA, 2,  0, 1'b0, 2,  10'h2AA};
        vecs[5] = '{1'b0, 10'h000, 0,  4, 1'b0, B,  10'h000};
        vecs[6] = '{1'b1, 10'h0FF, 5,  0, 1'b0, 5,  10'h0FF};

        rstn     = 1'b0;
        rx       = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) tick1();
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick1();
        check("post_rst_ready", tx_ready, 1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].inbound)
                run_inbound(vecs[i].data, vecs[i].len, vecs[i].exp_err,
                            vecs[i].exp_ack, vecs[i].exp_rx);
            else
                run_outbound(vecs[i].data, 1, vecs[i].resp, vecs[i].exp_ack);
            repeat (2) tick1();
        end

        // Simultaneous request and host packet: inbound first, packet kept.
        tx_data  = 10'h1B6;
        tx_valid = 1'b1;
        rx       = 1'b0;
        #1;
        check("prio_ready_low", tx_ready, 0);
        run_inbound(10'h09C, 6, 1'b0, 6, 10'h09C);
        run_outbound(10'h1B6, 0, 2, B);
        repeat (2) tick1();

        for (int it = 0; it < 10; it++) begin
            d = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                run_outbound(d, $urandom_range(0, 5), $urandom_range(1, 4), B);
            end else begin
                L = $urandom_range(2, 16);
                run_inbound(d, L, 1'b0, L, d);
            end
            repeat ($urandom_range(1, 3)) tick1();
        end

        // Reset while shifting out packet bits.
        tx_data  = 10'h2D3;
        tx_valid = 1'b1;
        tick1();
        tx_valid = 1'b0;
        n = 0;
        while (tx == 1'b0 && n < 100) begin n++; tick1(); end
        rx = 1'b0;
        tick1();
        rx = 1'b1;
        repeat (2 * B + B + 3 * B + 3) tick1();
        check("pre_rst_busy", busy, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_error", error, 0);
        check("midrst_rx_data", rx_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick1();
        check("midrst_ready_after", tx_ready, 1);
        repeat (2) tick1();

        // No ack after calibration pulse -> timeout abort.
        tx_data  = 10'h1C3;
        tx_valid = 1'b1;
        tick1();
        tx_valid = 1'b0;
        n = 0;
        while (tx == 1'b0 && n < 100) begin n++; tick1(); end
        check("to_cal_len", n, B);
        n = 0;
        while (error == 1'b0 && n < TO + 100) begin tick1(); n++; end
        check("timeout_cycles", n, TO + 1);
        check("to_tx", tx, 1);
        check("to_busy", busy, 0);
        check("to_ready", tx_ready, 1);
        tick1();
        check("to_error_pulse", error, 0);
        n = 0;
        repeat (3 * B) begin
            if (busy || tx == 1'b0) n++;
            tick1();
        end
        check("to_packet_dropped", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
